// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard for an in-order MIPS issue stage: per-register pending-write
// counters, RAW/capacity stall, flush. Optional forwarding: define SCOREBOARD_BYPASS_EN.
module dest_scoreboard #(
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_instr,
  output logic        issue_ready,
  output logic [4:0]  dest_reg,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic        flush,
  output logic [31:0] busy_mask,
  output logic        illegal,
  output logic        err_underflow
);

  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(PIPE_DEPTH);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      busy_d;
  logic             underflow;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       use_rs, use_rt;
  logic       rs_hazard, rt_hazard, cap_stall, issue_fire;
  logic [31:0] inc_vec, dec_vec;
  logic       unused_shamt;

  assign opcode       = issue_instr[31:26];
  assign rs           = issue_instr[25:21];
  assign rt           = issue_instr[20:16];
  assign rd           = issue_instr[15:11];
  assign funct        = issue_instr[5:0];
  assign unused_shamt = ^issue_instr[10:6];

  always_comb begin
    dest_reg = '0;
    illegal  = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    case (opcode)
      6'h00: begin
        use_rs = 1'b1;
        if (funct != 6'h08) begin
          dest_reg = rd;
          use_rt   = 1'b1;
        end
      end
      6'h01: begin
        use_rs = 1'b1;
        // BLTZAL / BGEZAL link into r31
        if (rt == 5'd16 || rt == 5'd17) dest_reg = 5'd31;
      end
      6'h02: ;
      6'h03: dest_reg = 5'd31;
      6'h04, 6'h05: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h06, 6'h07: use_rs = 1'b1;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        use_rs   = 1'b1;
        dest_reg = rt;
      end
      6'h0f: dest_reg = rt;
      6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    rs_hazard = use_rs && (rs != '0) && (cnt_q[rs] != '0);
    rt_hazard = use_rt && (rt != '0) && (cnt_q[rt] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    // Last outstanding write retiring this cycle can be forwarded
    if (wb_valid && (wb_reg == rs) && (cnt_q[rs] == CNT_W'(1))) rs_hazard = 1'b0;
    if (wb_valid && (wb_reg == rt) && (cnt_q[rt] == CNT_W'(1))) rt_hazard = 1'b0;
`endif
    cap_stall   = (dest_reg != '0) && (cnt_q[dest_reg] == MaxCnt);
    issue_ready = !flush && !rs_hazard && !rt_hazard && !cap_stall;
  end

  assign issue_fire = issue_valid && issue_ready;
  assign inc_vec    = (issue_fire && dest_reg != '0) ? (32'd1 << dest_reg) : '0;
  assign dec_vec    = (wb_valid && wb_reg != '0) ? (32'd1 << wb_reg) : '0;

  always_comb begin
    underflow = 1'b0;
    busy_d    = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (dec_vec[i] && cnt_q[i] == '0) begin
        underflow = 1'b1;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      busy_mask     <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      busy_mask     <= busy_d;
      err_underflow <= err_underflow | underflow;
    end
  end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Bench for dest_scoreboard: decode vector table, directed hazard sequences and a randomized run
// against a counter-array reference model.
module tb_dest_scoreboard;

  localparam int unsigned PIPE_DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_instr = '0;
  logic        issue_ready;
  logic [4:0]  dest_reg;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic [31:0] busy_mask;
  logic        illegal;
  logic        err_underflow;

  always #5 clk = ~clk;

  dest_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_instr   (issue_instr),
    .issue_ready   (issue_ready),
    .dest_reg      (dest_reg),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .busy_mask     (busy_mask),
    .illegal       (illegal),
    .err_underflow (err_underflow)
  );

  int checks = 0;
  int errors = 0;
  logic        last_ready, last_ill;
  logic [4:0]  last_dest;
  logic [31:0] saved_mask;
  bit          bypass;

  // Reference model: outstanding-write count per register plus sticky error
  int cnt [32];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic void m_decode(input logic [31:0] ins, output int dst, output bit ill,
                                   output bit urs, output bit urt);
    logic [5:0] op;
    op  = ins[31:26];
    dst = 0; ill = 0; urs = 0; urt = 0;
    case (op)
      6'h00: begin urs = 1; if (ins[5:0] != 6'h08) begin dst = int'(ins[15:11]); urt = 1; end end
      6'h01: begin urs = 1; if (ins[20:16] == 5'd16 || ins[20:16] == 5'd17) dst = 31; end
      6'h02: ;
      6'h03: dst = 31;
      6'h04, 6'h05: begin urs = 1; urt = 1; end
      6'h06, 6'h07: urs = 1;
      6'h0f: dst = int'(ins[20:16]);
      6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: begin urs = 1; urt = 1; end
      default: begin
        if ((op >= 6'h08 && op <= 6'h0e) || (op >= 6'h20 && op <= 6'h26)) begin
          urs = 1; dst = int'(ins[20:16]);
        end else ill = 1;
      end
    endcase
  endfunction

  function automatic bit m_hazard(input int r, input bit wv, input int wr);
    if (r == 0 || cnt[r] == 0) return 0;
`ifdef SCOREBOARD_BYPASS_EN
    if (cnt[r] == 1 && wv && wr == r) return 0;
`endif
    return 1;
  endfunction

  function automatic bit m_ready(input logic [31:0] ins, input bit fl, input bit wv, input int wr);
    int dst; bit ill, urs, urt;
    m_decode(ins, dst, ill, urs, urt);
    if (fl) return 0;
    if (urs && m_hazard(int'(ins[25:21]), wv, wr)) return 0;
    if (urt && m_hazard(int'(ins[20:16]), wv, wr)) return 0;
    if (dst != 0 && cnt[dst] == int'(PIPE_DEPTH)) return 0;
    return 1;
  endfunction

  function automatic void m_update(input bit acc, input int dst, input bit wv, input int wr,
                                   input bit fl);
    int inc, dec;
    if (fl) begin
      foreach (cnt[i]) cnt[i] = 0;
      return;
    end
    inc = (acc && dst != 0) ? dst : 0;
    dec = (wv && wr != 0) ? wr : 0;
    if (dec != 0 && cnt[dec] == 0) m_err = 1;
    if (inc != 0 && inc != dec) cnt[inc]++;
    if (dec != 0 && dec != inc && cnt[dec] > 0) cnt[dec]--;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < 32; i++) m[i] = (cnt[i] != 0);
    return m;
  endfunction

  // Drive one cycle (entered at posedge+1), check combinational outputs, then registered ones
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit wv, input logic [4:0] wr,
                       input bit fl);
    int dst; bit ill, urs, urt, rdy;
    issue_valid = iv; issue_instr = ins; wb_valid = wv; wb_reg = wr; flush = fl;
    m_decode(ins, dst, ill, urs, urt);
    rdy = m_ready(ins, fl, wv, int'(wr));
    #3;
    last_ready = issue_ready; last_dest = dest_reg; last_ill = illegal;
    check("dest_reg", 32'(dest_reg), 32'(dst));
    check("illegal", 32'(illegal), 32'(ill));
    check("issue_ready", 32'(issue_ready), 32'(rdy));
    @(posedge clk);
    #1;
    m_update(iv && rdy, dst, wv, int'(wr), fl);
    check("busy_mask", busy_mask, m_mask());
    check("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_valid = 1'b1; issue_instr = i_type(6'h08, 5'd0, 5'd8, 16'd1);
    wb_valid = 1'b0; flush = 1'b0;
    #2;
    check("reset busy_mask", busy_mask, 32'h0);
    check("reset err_underflow", 32'(err_underflow), 32'h0);
    check("reset issue_ready", 32'(issue_ready), 32'h1);
    foreach (cnt[i]) cnt[i] = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  dest;
    logic        ill;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [4:0] regimm_rt [4];
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    regimm_rt[0] = 5'd0; regimm_rt[1] = 5'd1; regimm_rt[2] = 5'd16; regimm_rt[3] = 5'd17;
    case ($urandom_range(0, 11))
      0:  return r_type(a, b, c, 6'h20);
      1:  return r_type(a, 5'd0, 5'd0, 6'h08);
      2:  return i_type(6'h08, a, b, 16'($urandom));
      3:  return i_type(6'h0f, 5'd0, b, 16'($urandom));
      4:  return i_type(6'h23, a, b, 16'($urandom));
      5:  return i_type(6'h2b, a, b, 16'($urandom));
      6:  return i_type(6'h04, a, b, 16'($urandom));
      7:  return i_type(6'h06, a, 5'd0, 16'($urandom));
      8:  return {6'h02, 26'($urandom)};
      9:  return {6'h03, 26'($urandom)};
      10: return i_type(6'h01, a, regimm_rt[$urandom_range(0, 3)], 16'($urandom));
      default: return i_type(6'h3f, a, b, 16'($urandom));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] add_r9, lw_r5, jr_r31;
    int busy_regs [$];
    int wr;
`ifdef SCOREBOARD_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    add_r9 = r_type(5'd8, 5'd8, 5'd9, 6'h20);
    lw_r5  = i_type(6'h23, 5'd0, 5'd5, 16'd4);
    jr_r31 = r_type(5'd31, 5'd0, 5'd0, 6'h08);

    vecs[0]  = '{r_type(5'd1, 5'd2, 5'd3, 6'h20), 5'd3, 1'b0};
    vecs[1]  = '{jr_r31, 5'd0, 1'b0};
    vecs[2]  = '{i_type(6'h08, 5'd0, 5'd8, 16'd1), 5'd8, 1'b0};
    vecs[3]  = '{i_type(6'h0d, 5'd1, 5'd20, 16'd5), 5'd20, 1'b0};
    vecs[4]  = '{i_type(6'h0f, 5'd0, 5'd7, 16'h1234), 5'd7, 1'b0};
    vecs[5]  = '{i_type(6'h0b, 5'd2, 5'd9, 16'd3), 5'd9, 1'b0};
    vecs[6]  = '{lw_r5, 5'd5, 1'b0};
    vecs[7]  = '{i_type(6'h24, 5'd3, 5'd6, 16'd0), 5'd6, 1'b0};
    vecs[8]  = '{i_type(6'h2b, 5'd3, 5'd5, 16'd0), 5'd0, 1'b0};
    vecs[9]  = '{i_type(6'h04, 5'd1, 5'd2, 16'd8), 5'd0, 1'b0};
    vecs[10] = '{i_type(6'h07, 5'd1, 5'd0, 16'd8), 5'd0, 1'b0};
    vecs[11] = '{i_type(6'h01, 5'd1, 5'd16, 16'd8), 5'd31, 1'b0};
    vecs[12] = '{i_type(6'h01, 5'd1, 5'd1, 16'd8), 5'd0, 1'b0};
    vecs[13] = '{{6'h02, 26'h12345}, 5'd0, 1'b0};
    vecs[14] = '{{6'h03, 26'h12345}, 5'd31, 1'b0};
    vecs[15] = '{i_type(6'h12, 5'd4, 5'd4, 16'd0), 5'd0, 1'b1};

    @(posedge clk);
    #1;
    do_reset();

    foreach (vecs[i]) begin
      cycle(1'b0, vecs[i].instr, 1'b0, 5'd0, 1'b0);
      check($sformatf("vec%0d dest", i), 32'(last_dest), 32'(vecs[i].dest));
      check($sformatf("vec%0d illegal", i), 32'(last_ill), 32'(vecs[i].ill));
    end

    // ADDI r8 then dependent ADD r9,r8,r8; then retire r8 alongside the ADD
    cycle(1'b1, i_type(6'h08, 5'd0, 5'd8, 16'd1), 1'b0, 5'd0, 1'b0);
    check("addi busy8", 32'(busy_mask[8]), 32'h1);
    cycle(1'b1, add_r9, 1'b0, 5'd0, 1'b0);
    check("raw stall", 32'(last_ready), 32'h0);
    cycle(1'b1, add_r9, 1'b1, 5'd8, 1'b0);
    check("wb same-cycle ready", 32'(last_ready), 32'(bypass));
    cycle(1'b1, add_r9, 1'b0, 5'd0, 1'b0);
    check("ready after wb", 32'(last_ready), 32'h1);

    // Capacity: three LW r5 fill the counter
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, lw_r5, 1'b0, 5'd0, 1'b0);
      check($sformatf("lw%0d ready", i), 32'(last_ready), 32'h1);
    end
    cycle(1'b1, lw_r5, 1'b0, 5'd0, 1'b0);
    check("lw capacity stall", 32'(last_ready), 32'h0);
    cycle(1'b1, lw_r5, 1'b1, 5'd5, 1'b0);
    check("lw stall with wb", 32'(last_ready), 32'h0);
    cycle(1'b1, lw_r5, 1'b1, 5'd5, 1'b0);
    check("lw issue+wb", 32'(last_ready), 32'h1);
    cycle(1'b1, lw_r5, 1'b0, 5'd0, 1'b0);
    check("lw refill", 32'(last_ready), 32'h1);
    cycle(1'b1, lw_r5, 1'b0, 5'd0, 1'b0);
    check("lw stall again", 32'(last_ready), 32'h0);

    // Link registers: JAL, BGEZAL, then JR r31 waits for both to retire
    do_reset();
    cycle(1'b1, {6'h03, 26'h100}, 1'b0, 5'd0, 1'b0);
    check("jal dest", 32'(last_dest), 32'd31);
    check("jal busy31", 32'(busy_mask[31]), 32'h1);
    cycle(1'b1, i_type(6'h01, 5'd0, 5'd17, 16'd4), 1'b0, 5'd0, 1'b0);
    check("bgezal dest", 32'(last_dest), 32'd31);
    cycle(1'b1, jr_r31, 1'b0, 5'd0, 1'b0);
    check("jr stall", 32'(last_ready), 32'h0);
    cycle(1'b0, jr_r31, 1'b1, 5'd31, 1'b0);
    cycle(1'b0, jr_r31, 1'b1, 5'd31, 1'b0);
    check("r31 retired", 32'(busy_mask[31]), 32'h0);
    cycle(1'b1, jr_r31, 1'b0, 5'd0, 1'b0);
    check("jr go", 32'(last_ready), 32'h1);

    // Underflow is sticky until reset; flush wins over a same-cycle issue
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 5'd12, 1'b0);
    check("underflow set", 32'(err_underflow), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    check("underflow held", 32'(err_underflow), 32'h1);
    do_reset();
    check("underflow cleared", 32'(err_underflow), 32'h0);
    cycle(1'b1, i_type(6'h08, 5'd0, 5'd7, 16'd1), 1'b0, 5'd0, 1'b0);
    cycle(1'b1, i_type(6'h08, 5'd0, 5'd8, 16'd1), 1'b0, 5'd0, 1'b1);
    check("flush ready", 32'(last_ready), 32'h0);
    check("flush clears", busy_mask, 32'h0);

    // Illegal opcode: accepted, nothing counted
    cycle(1'b1, i_type(6'h08, 5'd0, 5'd3, 16'd1), 1'b0, 5'd0, 1'b0);
    saved_mask = busy_mask;
    cycle(1'b1, i_type(6'h3f, 5'd3, 5'd3, 16'd0), 1'b0, 5'd0, 1'b0);
    check("illegal flag", 32'(last_ill), 32'h1);
    check("illegal dest", 32'(last_dest), 32'h0);
    check("illegal mask", busy_mask, saved_mask);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      busy_regs.delete();
      for (int r = 1; r < 32; r++) if (cnt[r] != 0) busy_regs.push_back(r);
      if (busy_regs.size() != 0 && $urandom_range(0, 4) != 0)
        wr = busy_regs[$urandom_range(0, busy_regs.size() - 1)];
      else
        wr = $urandom_range(0, 7);
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) == 0),
            5'(wr), 1'($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
